// File: rtl/risc_pkg.sv
// Shared definitions for the 8-bit RISC control unit: op-codes,
// FSM state encoding, bus select codes and IR field positions.
package risc_pkg;

  localparam int DATAWIDTH   = 8;
  localparam int OPCODE_SIZE = 4;
  localparam int SEL1_SIZE   = 3;
  localparam int SEL2_SIZE   = 2;

  // IR layout: op[7:4], src[3:2], dest[1:0]
  localparam int OP_MSB  = 7;
  localparam int OP_LSB  = 4;
  localparam int SRC_MSB = 3;
  localparam int SRC_LSB = 2;
  localparam int DST_MSB = 1;
  localparam int DST_LSB = 0;

  localparam logic [OPCODE_SIZE-1:0] OP_NOP = 4'd0;
  localparam logic [OPCODE_SIZE-1:0] OP_ADD = 4'd1;
  localparam logic [OPCODE_SIZE-1:0] OP_SUB = 4'd2;
  localparam logic [OPCODE_SIZE-1:0] OP_AND = 4'd3;
  localparam logic [OPCODE_SIZE-1:0] OP_NOT = 4'd4;
  localparam logic [OPCODE_SIZE-1:0] OP_RD  = 4'd5;
  localparam logic [OPCODE_SIZE-1:0] OP_WR  = 4'd6;
  localparam logic [OPCODE_SIZE-1:0] OP_BR  = 4'd7;
  localparam logic [OPCODE_SIZE-1:0] OP_BRZ = 4'd8;

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_FET1 = 4'd1,
    S_FET2 = 4'd2,
    S_DEC  = 4'd3,
    S_EX1  = 4'd4,
    S_RD1  = 4'd5,
    S_RD2  = 4'd6,
    S_WR1  = 4'd7,
    S_WR2  = 4'd8,
    S_BR1  = 4'd9,
    S_BR2  = 4'd10,
    S_HALT = 4'd11
  } state_t;

  localparam logic [SEL1_SIZE-1:0] B1_PC   = 3'd4;
  localparam logic [SEL2_SIZE-1:0] B2_ALU  = 2'd0;
  localparam logic [SEL2_SIZE-1:0] B2_BUS1 = 2'd1;
  localparam logic [SEL2_SIZE-1:0] B2_MEM  = 2'd2;

  function automatic logic [3:0] reg_onehot(
    input logic [1:0] r
  );
    return 4'b0001 << r;
  endfunction

endpackage

// File: rtl/risc_cu_output_decode.sv
// Combinational state/IR -> datapath strobe and select decoder.
// In: state, instruction, zero_flag, mem_ok. Out: all control strobes.
module risc_cu_output_decode
  import risc_pkg::*;
(
  input  state_t                 state,
  input  logic [DATAWIDTH-1:0]   instruction,
  input  logic                   zero_flag,
  input  logic                   mem_ok,
  output logic [3:0]             load_r,
  output logic                   load_pc,
  output logic                   inc_pc,
  output logic                   load_ir,
  output logic                   load_add_r,
  output logic                   load_reg_y,
  output logic                   load_reg_z,
  output logic [SEL1_SIZE-1:0]   sel_bus_1,
  output logic [SEL2_SIZE-1:0]   sel_bus_2,
  output logic [OPCODE_SIZE-1:0] alu_sel,
  output logic                   mem_write,
  output logic                   halted
);

  logic [OPCODE_SIZE-1:0] op;
  logic [1:0]             src;
  logic [1:0]             dst;

  assign op  = instruction[OP_MSB:OP_LSB];
  assign src = instruction[SRC_MSB:SRC_LSB];
  assign dst = instruction[DST_MSB:DST_LSB];

  always_comb begin
    load_r     = 4'b0000;
    load_pc    = 1'b0;
    inc_pc     = 1'b0;
    load_ir    = 1'b0;
    load_add_r = 1'b0;
    load_reg_y = 1'b0;
    load_reg_z = 1'b0;
    sel_bus_1  = '0;
    sel_bus_2  = '0;
    alu_sel    = OP_NOP;
    mem_write  = 1'b0;
    halted     = 1'b0;
    unique case (state)
      S_FET1: begin
        sel_bus_1  = B1_PC;
        sel_bus_2  = B2_BUS1;
        load_add_r = 1'b1;
        inc_pc     = 1'b1;
      end
      S_FET2: begin
        sel_bus_2 = B2_MEM;
        load_ir   = mem_ok;
      end
      S_DEC: begin
        unique case (1'b1)
          (op == OP_NOP): ;
          (op == OP_ADD) || (op == OP_SUB)
            || (op == OP_AND): begin
            sel_bus_1  = {1'b0, src};
            sel_bus_2  = B2_BUS1;
            load_reg_y = 1'b1;
          end
          (op == OP_NOT): begin
            sel_bus_1  = {1'b0, src};
            alu_sel    = OP_NOT;
            sel_bus_2  = B2_ALU;
            load_reg_z = 1'b1;
            load_r     = reg_onehot(dst);
          end
          (op == OP_RD) || (op == OP_WR): begin
            sel_bus_1  = B1_PC;
            sel_bus_2  = B2_BUS1;
            load_add_r = 1'b1;
            inc_pc     = 1'b1;
          end
          (op == OP_BR)
            || ((op == OP_BRZ) && zero_flag): begin
            sel_bus_1  = B1_PC;
            sel_bus_2  = B2_BUS1;
            load_add_r = 1'b1;
          end
          ((op == OP_BRZ) && !zero_flag): begin
            inc_pc = 1'b1;
          end
          default: ;
        endcase
      end
      S_EX1: begin
        sel_bus_1  = {1'b0, dst};
        alu_sel    = op;
        sel_bus_2  = B2_ALU;
        load_reg_z = 1'b1;
        load_r     = reg_onehot(dst);
      end
      S_RD1, S_WR1, S_BR1: begin
        sel_bus_2  = B2_MEM;
        load_add_r = mem_ok;
      end
      S_RD2: begin
        sel_bus_2 = B2_MEM;
        load_r    = mem_ok ? reg_onehot(dst) : 4'b0000;
      end
      S_WR2: begin
        sel_bus_1 = {1'b0, src};
        mem_write = mem_ok;
      end
      S_BR2: begin
        sel_bus_2 = B2_MEM;
        load_pc   = mem_ok;
      end
      S_HALT: halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/risc_control_unit.sv
// Multi-cycle control unit FSM for the 8-bit RISC machine.
// Ports: clk, rst_n, instruction, zero_flag, [mem_ready when
// RISC_CU_MEM_WAIT_EN], load_r, load_pc, inc_pc, load_ir, load_add_r,
// load_reg_y, load_reg_z, sel_bus_1, sel_bus_2, alu_sel, mem_write,
// halted. RISC_CU_MEM_WAIT_EN adds memory wait-state handshaking.
module risc_control_unit
  import risc_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [DATAWIDTH-1:0]   instruction,
  input  logic                   zero_flag,
`ifdef RISC_CU_MEM_WAIT_EN
  input  logic                   mem_ready,
`endif
  output logic [3:0]             load_r,
  output logic                   load_pc,
  output logic                   inc_pc,
  output logic                   load_ir,
  output logic                   load_add_r,
  output logic                   load_reg_y,
  output logic                   load_reg_z,
  output logic [SEL1_SIZE-1:0]   sel_bus_1,
  output logic [SEL2_SIZE-1:0]   sel_bus_2,
  output logic [OPCODE_SIZE-1:0] alu_sel,
  output logic                   mem_write,
  output logic                   halted
);

  state_t                 state;
  state_t                 state_nx;
  logic                   mem_ok;
  logic [OPCODE_SIZE-1:0] op;

`ifdef RISC_CU_MEM_WAIT_EN
  assign mem_ok = mem_ready;
`else
  assign mem_ok = 1'b1;
`endif

  assign op = instruction[OP_MSB:OP_LSB];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: state_nx = S_FET1;
      S_FET1: state_nx = S_FET2;
      S_FET2: if (mem_ok) state_nx = S_DEC;
      S_DEC: begin
        unique case (1'b1)
          (op == OP_NOP): state_nx = S_FET1;
          (op == OP_ADD) || (op == OP_SUB)
            || (op == OP_AND): state_nx = S_EX1;
          (op == OP_NOT): state_nx = S_FET1;
          (op == OP_RD):  state_nx = S_RD1;
          (op == OP_WR):  state_nx = S_WR1;
          (op == OP_BR)
            || ((op == OP_BRZ) && zero_flag):
            state_nx = S_BR1;
          ((op == OP_BRZ) && !zero_flag):
            state_nx = S_FET1;
          default: state_nx = S_HALT;
        endcase
      end
      S_EX1: state_nx = S_FET1;
      S_RD1: if (mem_ok) state_nx = S_RD2;
      S_RD2: if (mem_ok) state_nx = S_FET1;
      S_WR1: if (mem_ok) state_nx = S_WR2;
      S_WR2: if (mem_ok) state_nx = S_FET1;
      S_BR1: if (mem_ok) state_nx = S_BR2;
      S_BR2: if (mem_ok) state_nx = S_FET1;
      S_HALT: state_nx = S_HALT;
      default: state_nx = S_IDLE;
    endcase
  end

  risc_cu_output_decode u_dec (
    .state       (state),
    .instruction (instruction),
    .zero_flag   (zero_flag),
    .mem_ok      (mem_ok),
    .load_r      (load_r),
    .load_pc     (load_pc),
    .inc_pc      (inc_pc),
    .load_ir     (load_ir),
    .load_add_r  (load_add_r),
    .load_reg_y  (load_reg_y),
    .load_reg_z  (load_reg_z),
    .sel_bus_1   (sel_bus_1),
    .sel_bus_2   (sel_bus_2),
    .alu_sel     (alu_sel),
    .mem_write   (mem_write),
    .halted      (halted)
  );

endmodule

// File: tb/tb_risc_control_unit.sv
// Scoreboard bench for risc_control_unit: a per-instruction cycle model
// queues expected outputs; a negedge monitor pops and compares.
module tb_risc_control_unit;

  typedef struct packed {
    logic [3:0] lr;
    logic       pc;
    logic       inc;
    logic       ir;
    logic       ar;
    logic       ry;
    logic       rz;
    logic [2:0] s1;
    logic [1:0] s2;
    logic [3:0] alu;
    logic       mw;
    logic       h;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] instruction = 8'h00;
  logic       zero_flag = 1'b0;
  logic       mem_ready = 1'b1;

  logic [3:0] load_r;
  logic       load_pc, inc_pc, load_ir, load_add_r;
  logic       load_reg_y, load_reg_z, mem_write, halted;
  logic [2:0] sel_bus_1;
  logic [1:0] sel_bus_2;
  logic [3:0] alu_sel;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   budget = 1000000;
  int   rdy_cnt = 0;
  bit   mon_en = 1'b0;
  bit   wait_ok;

  always #5 clk = ~clk;

  risc_control_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instruction (instruction),
    .zero_flag   (zero_flag),
`ifdef RISC_CU_MEM_WAIT_EN
    .mem_ready   (mem_ready),
`endif
    .load_r      (load_r),
    .load_pc     (load_pc),
    .inc_pc      (inc_pc),
    .load_ir     (load_ir),
    .load_add_r  (load_add_r),
    .load_reg_y  (load_reg_y),
    .load_reg_z  (load_reg_z),
    .sel_bus_1   (sel_bus_1),
    .sel_bus_2   (sel_bus_2),
    .alu_sel     (alu_sel),
    .mem_write   (mem_write),
    .halted      (halted)
  );

  always @(negedge clk) begin
    exp_t act;
    exp_t ex;
    if (mon_en) begin
      act = {load_r, load_pc, inc_pc, load_ir, load_add_r,
             load_reg_y, load_reg_z, sel_bus_1, sel_bus_2,
             alu_sel, mem_write, halted};
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL underflow t=%0t got=%h want=none",
                 $time, act);
      end else begin
        ex = sb.pop_front();
        if (act !== ex) begin
          failures++;
          $display("FAIL outputs t=%0t ins=%h got=%h want=%h",
                   $time, instruction, act, ex);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input exp_t e, input logic rdy);
    mem_ready = rdy;
    rdy_cnt += int'(rdy);
    sb.push_back(e);
    step();
  endtask

  function automatic exp_t gate(input exp_t e);
    exp_t g = e;
    g.lr = '0; g.pc = 0; g.inc = 0; g.ir = 0;
    g.ar = 0; g.ry = 0; g.rz = 0; g.mw = 0;
    return g;
  endfunction

  // mem: phase waits on memory; w: forced wait count (-1 = random)
  task automatic add(input exp_t e, input bit mem, input int w);
    int n;
    if (budget == 0) return;
    budget--;
    if (mem && wait_ok) begin
      n = (w < 0) ? int'($urandom_range(0, 2)) : w;
      for (int k = 0; k < n; k++) push(gate(e), 1'b0);
      push(e, 1'b1);
    end else begin
      push(e, wait_ok ? 1'($urandom_range(0, 1)) : 1'b1);
    end
  endtask

  // Issue one instruction: cycle-by-cycle expected outputs
  task automatic run_ins(input logic [7:0] ins, input logic z,
                         input int rd2_wait);
    int   op  = int'(ins[7:4]);
    int   src = int'(ins[3:2]);
    int   dst = int'(ins[1:0]);
    exp_t e;
    instruction = ins;
    zero_flag   = z;
    e = '0; e.s1 = 4; e.s2 = 1; e.ar = 1; e.inc = 1;
    add(e, 0, 0);
    e = '0; e.s2 = 2; e.ir = 1;
    add(e, 1, -1);
    e = '0;
    case (op)
      0: add(e, 0, 0);
      1, 2, 3: begin
        e.s1 = 3'(src); e.s2 = 1; e.ry = 1;
        add(e, 0, 0);
        e = '0; e.s1 = 3'(dst); e.alu = 4'(op);
        e.rz = 1; e.lr = 4'(1 << dst);
        add(e, 0, 0);
      end
      4: begin
        e.s1 = 3'(src); e.alu = 4; e.rz = 1;
        e.lr = 4'(1 << dst);
        add(e, 0, 0);
      end
      5, 6: begin
        e.s1 = 4; e.s2 = 1; e.ar = 1; e.inc = 1;
        add(e, 0, 0);
        e = '0; e.s2 = 2; e.ar = 1;
        add(e, 1, -1);
        e = '0;
        if (op == 5) begin
          e.s2 = 2; e.lr = 4'(1 << dst);
          add(e, 1, rd2_wait);
        end else begin
          e.s1 = 3'(src); e.mw = 1;
          add(e, 1, -1);
        end
      end
      7, 8: begin
        if (op == 7 || z) begin
          e.s1 = 4; e.s2 = 1; e.ar = 1;
          add(e, 0, 0);
          e = '0; e.s2 = 2; e.ar = 1;
          add(e, 1, -1);
          e = '0; e.s2 = 2; e.pc = 1;
          add(e, 1, -1);
        end else begin
          e.inc = 1;
          add(e, 0, 0);
        end
      end
      default: add(e, 0, 0);
    endcase
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    push('0, 1'b1);
    push('0, 1'b1);
    rst_n = 1'b1;
    push('0, 1'b1);
  endtask

  function automatic logic [7:0] rnd_legal();
    logic [7:0] r = 8'($urandom);
    r[7:4] = 4'($urandom_range(0, 8));
    return r;
  endfunction

  initial begin
    exp_t hx;
`ifdef RISC_CU_MEM_WAIT_EN
    wait_ok = 1'b1;
`else
    wait_ok = 1'b0;
`endif
    step();
    mon_en = 1'b1;
    do_reset();
    run_ins(8'h00, 1'b0, -1);
    run_ins(8'h00, 1'b1, -1);
    run_ins(8'h16, 1'b0, -1);
    run_ins(8'h80, 1'b0, -1);
    run_ins(8'h80, 1'b1, -1);
    run_ins(8'h6C, 1'b0, -1);
    run_ins(8'h52, 1'b0, 3);
    run_ins(8'h4B, 1'b1, -1);
    run_ins(8'h7F, 1'b0, -1);
    run_ins(8'h3F, 1'b0, -1);
    for (int i = 0; i < 60; i++)
      run_ins(rnd_legal(), 1'($urandom), -1);
    // reset lands in the WR2 cycle: the write must not appear
    budget = 4;
    run_ins(8'h6C, 1'b0, -1);
    budget = 1000000;
    do_reset();
    run_ins(8'h2D, 1'b0, -1);
    run_ins(8'hF0, 1'b0, -1);
    hx = '0; hx.h = 1'b1;
    for (int i = 0; i < 20; i++) begin
      instruction = 8'($urandom);
      zero_flag = 1'($urandom);
      push(hx, 1'($urandom));
    end
    do_reset();
    for (int i = 0; i < 20; i++)
      run_ins(rnd_legal(), 1'($urandom), -1);
    run_ins(8'h9A, 1'b1, -1);
    push(hx, 1'b1);
    push(hx, 1'b1);
    do_reset();
    mon_en = 1'b0;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain left=%0d want=0", sb.size());
    end
    $display("memory-ready cycles driven: %0d", rdy_cnt);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
